serial_add_sequencer: RTL and testbench
=======================================

Name: serial_add_sequencer

Overview:
- Bit-serial multi-bit adder controller that time-shares one 1-bit adder cell across WIDTH cycles.
- The 1-bit cell is a full adder built from two param_half_adder instances (WIDTH=1) plus an OR of their carries.
- The sequencer loads the operands, shifts them LSB-first through the cell, tracks the carry, and assembles the result.
- It is the first consumer of param_half_adder beyond its unit bench; it targets area-constrained datapaths where a ripple adder is too large.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived localparam, not user-set).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request an add; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  WIDTH  result bits; held until the next accepted start.
- cout  output  1  final carry-out; held with sum.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, sum=0, cout=0; shift regs, carry and counter cleared. rst has priority over all other inputs.
- FSM states:
  - IDLE:
    - start=1 at edge E0 -> load sa<=a, sb<=b, carry<=0, cnt<=0, clear result shift reg; go RUN.
    - start=0 -> stay in IDLE.
  - RUN (per edge):
    - Cell inputs are sa[0], sb[0], carry.
    - HA1: x = sa[0]^sb[0], c1 = sa[0]&sb[0].
    - HA2: s = x^carry, c2 = x&carry.
    - Updates: carry <= c1|c2; result shifts right with s entering at the MSB; sa, sb shift right; cnt++.
    - When cnt==WIDTH-1 at an edge, that edge (E_WIDTH) processes the last bit and goes DONE. sum <= final result shift reg, cout <= final carry.
  - DONE: lasts exactly one cycle with done=1; next edge -> IDLE.
- Latency: start accepted at E0; done high in the cycle following edge E_WIDTH; back in IDLE after E_WIDTH+1. Min start-to-start spacing is WIDTH+2 cycles.
- busy=1 in RUN and DONE, registered, rising in the cycle after E0.
- start while busy (RUN or DONE): ignored, with no queuing. Operands changing during RUN have no effect.
- sum/cout keep their last completed value through IDLE and the following RUN; they update only at E_WIDTH.
- WIDTH=1: RUN lasts one edge; result equals the full-add of a[0]+b[0] with cin=0.
- Overflow: wraps modulo 2^WIDTH; the lost bit appears on cout.
- Reset mid-RUN or in DONE: abort; no done pulse; outputs forced to reset values on that edge.
- done and busy are registered outputs, never combinational from start.

Decomposition:
- Shared include/package serial_add_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 unreachable; it decodes to IDLE on the next edge);
  - the bit-cell carry-combine constant (OR) documentation.
- One natural sub-module, serial_add_cell: a 1-bit full adder made of two param_half_adder (WIDTH=1) instances plus an OR. It is combinational; the sequencer owns all registers.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 -> busy=0, done=0, sum=8'h00, cout=0 held for 10 cycles.
- Carry ripple, WIDTH=8: a=8'hFF, b=8'h01, start pulse at E0 -> busy=1 from E0+1; done=1 only in the cycle after E8; sum=8'h00, cout=1; IDLE after E9.
- No carry: a=8'hA5, b=8'h5A -> sum=8'hFF, cout=0, done exactly once; then a=8'h80, b=8'h80 -> sum=8'h00, cout=1.
- Start while busy: second start=1 with a=8'h01, b=8'h01 at E3 and again during DONE -> ignored; result is still from the first op (8'h12+8'h34 -> sum=8'h46, cout=0), one done pulse only.
- Reset mid-operation: start at E0 with 8'hFF+8'hFF, rst=1 at E4 -> no done, sum=0, cout=0, busy=0 next cycle. A fresh start then gives sum=8'hFE, cout=1.
- WIDTH=1 instance, exhaustive (0+0, 1+0, 0+1, 1+1) -> (sum,cout) = (0,0), (1,0), (1,0), (0,1), each with done in the cycle after E1.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
// The bit cell combines its two half-adder carries with an OR: at most one of
// them can be set for any input combination, so OR and XOR agree and OR is used.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
        // 2'd3 is unreachable and decodes back to ST_IDLE on the next edge.
    } state_t;

endpackage

// File: rtl/param_half_adder.sv
// Bitwise half adder: per-bit sum and carry for WIDTH independent bit pairs.
module param_half_adder #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_cell.sv
// 1-bit full adder built from two 1-bit half adders and an OR of their carries.
// Purely combinational; the sequencer owns every register.
module serial_add_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic x;
    logic c1;
    logic c2;

    param_half_adder #(
        .WIDTH (1)
    ) u_ha1 (
        .a (a),
        .b (b),
        .s (x),
        .c (c1)
    );

    param_half_adder #(
        .WIDTH (1)
    ) u_ha2 (
        .a (x),
        .b (cin),
        .s (s),
        .c (c2)
    );

    assign cout = c1 | c2;

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB-first through a single
// full-adder cell, one bit per clock, with the result assembled MSB-in.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             cell_s;
    logic             cell_c;
    logic [WIDTH-1:0] res_next;

    serial_add_cell u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (carry),
        .s    (cell_s),
        .cout (cell_c)
    );

    // Result register shifted right with the new sum bit entering at the MSB.
    always_comb begin
        res_next            = res >> 1;
        res_next[WIDTH-1]   = cell_s;
    end

    // Sequencer FSM with registered busy/done/sum/cout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        res   <= '0;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    carry <= cell_c;
                    res   <= res_next;
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        sum   <= res_next;
                        cout  <= cell_c;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer: an 8-bit instance and a 1-bit instance.
module tb_serial_add_sequencer;

    logic       clk;
    logic       rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int tests;
    int fails;
    logic [7:0] last_sum;
    logic       last_cout;

    serial_add_sequencer #(
        .WIDTH (8)
    ) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_add_sequencer #(
        .WIDTH (1)
    ) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full 8-bit add with timing checks around E0, E1..E7, E8 and E9.
    task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] esum, input logic ecout);
        int pulses;
        int busy_low;
        int sum_moved;
        a8 = x;
        b8 = y;
        start8 = 1'b1;
        tick();                          // E0
        start8 = 1'b0;
        check({tag, "_busy_e0"}, 32'(busy8), 32'd1);
        check({tag, "_done_e0"}, 32'(done8), 32'd0);
        pulses = 0;
        busy_low = 0;
        sum_moved = 0;
        for (int i = 1; i <= 7; i++) begin
            tick();                      // E1..E7
            if (done8) pulses++;
            if (!busy8) busy_low++;
            if (sum8 !== last_sum || cout8 !== last_cout) sum_moved++;
        end
        check({tag, "_early_done"}, 32'(pulses), 32'd0);
        check({tag, "_busy_run"}, 32'(busy_low), 32'd0);
        check({tag, "_sum_held"}, 32'(sum_moved), 32'd0);
        tick();                          // E8
        check({tag, "_done_e8"}, 32'(done8), 32'd1);
        check({tag, "_sum"}, 32'(sum8), 32'(esum));
        check({tag, "_cout"}, 32'(cout8), 32'(ecout));
        tick();                          // E9
        check({tag, "_done_e9"}, 32'(done8), 32'd0);
        check({tag, "_busy_e9"}, 32'(busy8), 32'd0);
        last_sum = esum;
        last_cout = ecout;
    endtask

    task automatic op1(input string tag, input logic x, input logic y,
                       input logic esum, input logic ecout);
        a1 = x;
        b1 = y;
        start1 = 1'b1;
        tick();                          // E0
        start1 = 1'b0;
        check({tag, "_busy_e0"}, 32'(busy1), 32'd1);
        check({tag, "_done_e0"}, 32'(done1), 32'd0);
        tick();                          // E1
        check({tag, "_done_e1"}, 32'(done1), 32'd1);
        check({tag, "_sum"}, 32'(sum1), 32'(esum));
        check({tag, "_cout"}, 32'(cout1), 32'(ecout));
        tick();                          // E2
        check({tag, "_idle"}, 32'({busy1, done1}), 32'd0);
    endtask

    initial begin
        int bad;
        tests = 0;
        fails = 0;
        last_sum = 8'h00;
        last_cout = 1'b0;
        rst = 1'b1;
        start8 = 1'b0;
        a8 = 8'h00;
        b8 = 8'h00;
        start1 = 1'b0;
        a1 = 1'b0;
        b1 = 1'b0;

        // Reset then idle.
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", 32'(busy8), 32'd0);
        check("reset_done", 32'(done8), 32'd0);
        check("reset_sum", 32'(sum8), 32'h00);
        check("reset_cout", 32'(cout8), 32'd0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy8 || done8 || sum8 !== 8'h00 || cout8) bad++;
        end
        check("idle_hold", 32'(bad), 32'd0);

        // Carry ripple, no carry, overflow.
        op8("ripple", 8'hFF, 8'h01, 8'h00, 1'b1);
        op8("nocarry", 8'hA5, 8'h5A, 8'hFF, 1'b0);
        op8("ovf", 8'h80, 8'h80, 8'h00, 1'b1);

        // Start while busy: extra starts at E3 and during DONE are ignored.
        a8 = 8'h12;
        b8 = 8'h34;
        start8 = 1'b1;
        tick();                          // E0
        start8 = 1'b0;
        tick();                          // E1
        tick();                          // E2
        a8 = 8'h01;
        b8 = 8'h01;
        start8 = 1'b1;
        tick();                          // E3
        start8 = 1'b0;
        for (int i = 4; i <= 8; i++) tick();
        check("busy_start_done", 32'(done8), 32'd1);
        check("busy_start_sum", 32'(sum8), 32'h46);
        check("busy_start_cout", 32'(cout8), 32'd0);
        start8 = 1'b1;                   // during DONE
        tick();                          // E9
        start8 = 1'b0;
        check("busy_start_e9", 32'({busy8, done8}), 32'd0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (busy8 || done8) bad++;
        end
        check("busy_start_ignored", 32'(bad), 32'd0);
        check("busy_start_held", 32'(sum8), 32'h46);
        last_sum = 8'h46;
        last_cout = 1'b0;

        // Reset mid-operation.
        a8 = 8'hFF;
        b8 = 8'hFF;
        start8 = 1'b1;
        tick();                          // E0
        start8 = 1'b0;
        tick();
        tick();
        tick();                          // E3
        rst = 1'b1;
        tick();                          // E4
        rst = 1'b0;
        check("midrst_state", 32'({busy8, done8, cout8}), 32'd0);
        check("midrst_sum", 32'(sum8), 32'h00);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy8 || done8) bad++;
        end
        check("midrst_no_done", 32'(bad), 32'd0);
        last_sum = 8'h00;
        last_cout = 1'b0;
        op8("after_rst", 8'hFF, 8'hFF, 8'hFE, 1'b1);

        // WIDTH=1 exhaustive.
        op1("w1_00", 1'b0, 1'b0, 1'b0, 1'b0);
        op1("w1_10", 1'b1, 1'b0, 1'b1, 1'b0);
        op1("w1_01", 1'b0, 1'b1, 1'b1, 1'b0);
        op1("w1_11", 1'b1, 1'b1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
